// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   modport master (
      output dm_req,
      output dm_we,
      output dm_addr,
      output dm_wdata,
      input  dm_ack,
      input  dm_rdata
   );

   modport slave (
      input  dm_req,
      input  dm_we,
      input  dm_addr,
      input  dm_wdata,
      output dm_ack,
      output dm_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues load/store accesses over a variable-latency req/ack bus,
// stalls upstream while an access is outstanding and registers the MEM/WB pipeline register.
module mem_stage #(
   parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0020,
   parameter int unsigned TIMEOUT_CYC  = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       me_aluresult,
   input  logic [31:0]       me_d2,
   input  logic [4:0]        me_td,
   input  logic              me_WREG,
   input  logic              me_WMEM,
   input  logic              me_LW,
   input  logic [31:0]       me_instr,
   mem_stage_if.master       dm,
   output logic              stall,
   output logic [31:0]       wb_aluresult,
   output logic [31:0]       wb_mdata,
   output logic [4:0]        wb_td,
   output logic              wb_WREG,
   output logic              wb_LW,
   output logic [31:0]       wb_instr,
   output logic              err_misalign,
   output logic              err_timeout
);

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t     state;
   logic [7:0] tcnt;

   logic mem_op;
   logic aligned;
   logic in_idle;
   logic in_wait;
   logic timeout_abort;
   logic req_raw;
   logic complete;
   logic take_inputs;

   always_comb begin
      mem_op        = me_LW | me_WMEM;
      aligned       = (me_aluresult[1:0] == 2'b00);
      in_idle       = (state == S_IDLE);
      in_wait       = (state == S_WAIT);
      timeout_abort = in_wait & (tcnt == TO_LIM) & ~dm.dm_ack;
      req_raw       = ~timeout_abort & ((in_idle & mem_op & aligned) | in_wait);
      // Request and stall are gated by reset so nothing leaks out while held in reset.
      dm.dm_req     = rst & req_raw;
      dm.dm_we      = me_WMEM & ~me_LW;
      dm.dm_addr    = me_aluresult;
      dm.dm_wdata   = me_d2;
      stall         = dm.dm_req & ~dm.dm_ack;
      complete      = dm.dm_req & dm.dm_ack;
      take_inputs   = (in_idle & ~mem_op) | complete;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         tcnt         <= '0;
         wb_aluresult <= '0;
         wb_mdata     <= '0;
         wb_td        <= '0;
         wb_WREG      <= 1'b0;
         wb_LW        <= 1'b0;
         wb_instr     <= BUBBLE_INSTR;
         err_misalign <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         err_misalign <= in_idle & mem_op & ~aligned;
         err_timeout  <= timeout_abort;

         // Every cycle the WB register takes either the instruction or a bubble.
         if (take_inputs) begin
            wb_aluresult <= me_aluresult;
            wb_mdata     <= (complete & me_LW) ? dm.dm_rdata : '0;
            wb_td        <= me_td;
            wb_WREG      <= me_WREG & (me_td != '0);
            wb_LW        <= me_LW;
            wb_instr     <= me_instr;
         end else begin
            wb_aluresult <= '0;
            wb_mdata     <= '0;
            wb_td        <= '0;
            wb_WREG      <= 1'b0;
            wb_LW        <= 1'b0;
            wb_instr     <= BUBBLE_INSTR;
         end

         case (state)
            S_IDLE: begin
               if (mem_op & aligned & ~dm.dm_ack) begin
                  state <= S_WAIT;
                  tcnt  <= 8'd1;
               end
            end
            S_WAIT: begin
               if (dm.dm_ack | timeout_abort) begin
                  state <= S_IDLE;
                  tcnt  <= '0;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               tcnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: expected WB contents are queued as each
// instruction is driven and compared after the capturing clock edge.
module tb_mem_stage;

   localparam logic [31:0] BUB = 32'h0000_0020;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] mdata;
      logic [4:0]  td;
      logic        wreg;
      logic        lw;
      logic [31:0] instr;
      logic        mis;
      logic        to;
   } wb_t;

   logic        clk;
   logic        rst;
   logic [31:0] me_aluresult;
   logic [31:0] me_d2;
   logic [4:0]  me_td;
   logic        me_WREG;
   logic        me_WMEM;
   logic        me_LW;
   logic [31:0] me_instr;
   logic        stall;
   logic [31:0] wb_aluresult;
   logic [31:0] wb_mdata;
   logic [4:0]  wb_td;
   logic        wb_WREG;
   logic        wb_LW;
   logic [31:0] wb_instr;
   logic        err_misalign;
   logic        err_timeout;

   int unsigned total = 0;
   int unsigned bad   = 0;
   wb_t         sb[$];

   mem_stage_if bus ();

   mem_stage #(
      .BUBBLE_INSTR (BUB),
      .TIMEOUT_CYC  (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .me_aluresult (me_aluresult),
      .me_d2        (me_d2),
      .me_td        (me_td),
      .me_WREG      (me_WREG),
      .me_WMEM      (me_WMEM),
      .me_LW        (me_LW),
      .me_instr     (me_instr),
      .dm           (bus.master),
      .stall        (stall),
      .wb_aluresult (wb_aluresult),
      .wb_mdata     (wb_mdata),
      .wb_td        (wb_td),
      .wb_WREG      (wb_WREG),
      .wb_LW        (wb_LW),
      .wb_instr     (wb_instr),
      .err_misalign (err_misalign),
      .err_timeout  (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic wb_t bub(input logic mis, input logic to);
      wb_t r;
      r       = '0;
      r.instr = BUB;
      r.mis   = mis;
      r.to    = to;
      return r;
   endfunction

   function automatic wb_t ins(input logic [31:0] alu, input logic [31:0] mdata,
                               input logic [4:0] td, input logic wreg, input logic lw,
                               input logic [31:0] instr);
      wb_t r;
      r.alu   = alu;
      r.mdata = mdata;
      r.td    = td;
      r.wreg  = wreg;
      r.lw    = lw;
      r.instr = instr;
      r.mis   = 1'b0;
      r.to    = 1'b0;
      return r;
   endfunction

   function automatic wb_t observed();
      wb_t r;
      r.alu   = wb_aluresult;
      r.mdata = wb_mdata;
      r.td    = wb_td;
      r.wreg  = wb_WREG;
      r.lw    = wb_LW;
      r.instr = wb_instr;
      r.mis   = err_misalign;
      r.to    = err_timeout;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] td,
                        input logic wreg, input logic wmem, input logic lw,
                        input logic [31:0] instr, input logic ack, input logic [31:0] rdata);
      me_aluresult = alu;
      me_d2        = d2;
      me_td        = td;
      me_WREG      = wreg;
      me_WMEM      = wmem;
      me_LW        = lw;
      me_instr     = instr;
      bus.dm_ack   = ack;
      bus.dm_rdata = rdata;
   endtask

   // Called 1 time unit after a rising edge: checks the bus mid-cycle, then WB after the next edge.
   task automatic step(input string tag, input logic e_req, input logic e_stall, input wb_t e_wb);
      logic [66:0] e_bus;
      logic [66:0] o_bus;
      wb_t         e;
      #4;
      e_bus = {e_req, e_stall, me_WMEM & ~me_LW, me_aluresult, me_d2};
      o_bus = {bus.dm_req, stall, bus.dm_we, bus.dm_addr, bus.dm_wdata};
      chk({tag, "_bus"}, 128'(o_bus), 128'(e_bus));
      sb.push_back(e_wb);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, "_wb"}, 128'(observed()), 128'(e));
   endtask

   initial begin
      rst = 1'b0;
      drive(32'h0000_0100, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 32'h0);

      // 1. Reset values and gating of req/stall, then a plain ALU op
      #12;
      chk("rst_bus", 128'({bus.dm_req, stall}), 128'(2'b00));
      chk("rst_wb", 128'(observed()), 128'(bub(1'b0, 1'b0)));
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h1111_0001, 1'b0, 32'h0);
      step("alu", 1'b0, 1'b0, ins(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 32'h1111_0001));

      // 2. Zero-wait load
      drive(32'h0000_0100, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 32'h2222_0002, 1'b1, 32'hDEAD_BEEF);
      step("lw0", 1'b1, 1'b0, ins(32'h100, 32'hDEAD_BEEF, 5'd3, 1'b1, 1'b1, 32'h2222_0002));

      // 3. Store acknowledged on the fourth request cycle
      drive(32'h0000_0040, 32'h0000_CAFE, 5'd7, 1'b0, 1'b1, 1'b0, 32'h3333_0003, 1'b0, 32'h0);
      step("sw_w0", 1'b1, 1'b1, bub(1'b0, 1'b0));
      step("sw_w1", 1'b1, 1'b1, bub(1'b0, 1'b0));
      step("sw_w2", 1'b1, 1'b1, bub(1'b0, 1'b0));
      bus.dm_ack = 1'b1;
      step("sw_ack", 1'b1, 1'b0, ins(32'h40, 32'h0, 5'd7, 1'b0, 1'b0, 32'h3333_0003));

      // Ack with no request is ignored; store with WREG=1 passes it through
      drive(32'h0000_0008, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h4444_0004, 1'b1, 32'h5555_5555);
      step("ack_idle", 1'b0, 1'b0, ins(32'h8, 32'h0, 5'd2, 1'b1, 1'b0, 32'h4444_0004));
      drive(32'h0000_0044, 32'h0000_1357, 5'd9, 1'b1, 1'b1, 1'b0, 32'h4444_0005, 1'b1, 32'h5555_5555);
      step("sw_wreg", 1'b1, 1'b0, ins(32'h44, 32'h0, 5'd9, 1'b1, 1'b0, 32'h4444_0005));

      // Load and store both set: treated as a load
      drive(32'h0000_0048, 32'h0000_2468, 5'd10, 1'b1, 1'b1, 1'b1, 32'h4444_0006, 1'b1, 32'h0BAD_F00D);
      step("lw_sw", 1'b1, 1'b0, ins(32'h48, 32'h0BAD_F00D, 5'd10, 1'b1, 1'b1, 32'h4444_0006));

      // 4. Misaligned load is dropped with a one-cycle error pulse
      drive(32'h0000_0102, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 32'h5555_0007, 1'b0, 32'h0);
      step("misal", 1'b0, 1'b0, bub(1'b1, 1'b0));
      drive(32'h0000_0077, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0, 32'h5555_0008, 1'b0, 32'h0);
      step("misal_end", 1'b0, 1'b0, ins(32'h77, 32'h0, 5'd11, 1'b1, 1'b0, 32'h5555_0008));

      // 5. Timeout after four stalled cycles, then the next instruction is accepted
      drive(32'h0000_0200, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 32'h6666_0009, 1'b0, 32'h0);
      step("to_w0", 1'b1, 1'b1, bub(1'b0, 1'b0));
      step("to_w1", 1'b1, 1'b1, bub(1'b0, 1'b0));
      step("to_w2", 1'b1, 1'b1, bub(1'b0, 1'b0));
      step("to_w3", 1'b1, 1'b1, bub(1'b0, 1'b0));
      step("to_abort", 1'b0, 1'b0, bub(1'b0, 1'b1));
      drive(32'h0000_0ABC, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 32'h6666_000A, 1'b0, 32'h0);
      step("to_next", 1'b0, 1'b0, ins(32'hABC, 32'h0, 5'd12, 1'b1, 1'b0, 32'h6666_000A));

      // 6. Reset asserted mid-WAIT, late ack after release, then x0-guarded load
      drive(32'h0000_0300, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 32'h7777_000B, 1'b0, 32'h0);
      step("rw_w0", 1'b1, 1'b1, bub(1'b0, 1'b0));
      drive(32'h0000_0300, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 32'h7777_000B, 1'b1, 32'h1234_5678);
      rst = 1'b0;
      #1;
      chk("rw_rst_bus", 128'({bus.dm_req, stall}), 128'(2'b00));
      chk("rw_rst_wb", 128'(observed()), 128'(bub(1'b0, 1'b0)));
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, BUB, 1'b1, 32'h1234_5678);
      step("late_ack", 1'b0, 1'b0, ins(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, BUB));
      drive(32'h0000_0010, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h7777_000C, 1'b1, 32'hFEED_FACE);
      step("lw_x0", 1'b1, 1'b0, ins(32'h10, 32'hFEED_FACE, 5'd0, 1'b0, 1'b1, 32'h7777_000C));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
